// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding,
// default parameter values and the channel counter width helper.
// Optional long-press support is enabled with DEBOUNCE_LONG_PRESS_EN.
package debounce_pkg;

   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_CHECK  = 1'b1
   } deb_state_t;

   localparam int DEF_NUM_CH         = 4;
   localparam int DEF_PRESCALE_WIDTH = 16;
   localparam int DEF_STABLE_TICKS   = 4;
   localparam int DEF_LONG_TICKS     = 64;
   localparam int HOLD_CNT_W         = 16;

   // Width of the per-channel mismatch counter; never narrower than one bit.
   function automatic int cnt_width(input int stable_ticks);
      int w;
      w = $clog2(stable_ticks);
      if (w < 1) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: mismatch-counting FSM that flips LEVEL after
// STABLE_TICKS consecutive disagreeing ticks, with registered PRESS/RELEASE
// pulses. When DEBOUNCE_LONG_PRESS_EN is defined, a saturating hold counter
// raises a single HOLD pulse after LEVEL has been high for LONG_TICKS ticks.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int STABLE_TICKS = DEF_STABLE_TICKS,
   parameter int LONG_TICKS   = DEF_LONG_TICKS
) (
   input  logic CLK,
   input  logic RST,
   input  logic TICK,
   input  logic SYNC,
   output logic LEVEL,
   output logic PRESS,
   output logic RELEASE,
   output logic HOLD
);

   localparam int             CW       = cnt_width(STABLE_TICKS);
   localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_TICKS - 1);

   if (STABLE_TICKS < 2 || STABLE_TICKS > 255 || LONG_TICKS < 2 || LONG_TICKS > 65535) begin : g_bad_param
      $error("debounce_channel: STABLE_TICKS or LONG_TICKS out of range");
   end

   deb_state_t    r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic          r_level, w_level_nxt;
   logic          r_press, w_press_nxt;
   logic          r_release, w_release_nxt;

   // State, counter, level and pulse registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= ST_STABLE;
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_level   <= w_level_nxt;
         r_press   <= w_press_nxt;
         r_release <= w_release_nxt;
      end
   end

   // Next-state logic; only tick cycles advance the FSM, otherwise everything holds
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_level_nxt   = r_level;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      if (TICK) begin
         case (r_state)
            ST_STABLE: begin
               if (SYNC != r_level) begin
                  w_cnt_nxt   = CW'(1);
                  w_state_nxt = ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (SYNC == r_level) begin
                  // bounce: input went back before the level could flip
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_STABLE;
               end else if (r_cnt == CNT_LAST) begin
                  w_level_nxt   = SYNC;
                  w_cnt_nxt     = '0;
                  w_state_nxt   = ST_STABLE;
                  w_press_nxt   = SYNC;
                  w_release_nxt = ~SYNC;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
            default: begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_STABLE;
            end
         endcase
      end
   end

   assign LEVEL   = r_level;
   assign PRESS   = r_press;
   assign RELEASE = r_release;

`ifdef DEBOUNCE_LONG_PRESS_EN
   localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(LONG_TICKS);

   logic [HOLD_CNT_W-1:0] r_hold_cnt;
   logic                  r_hold;

   // Long-press counter: cleared while low, saturates so HOLD fires once per press
   always_ff @(posedge CLK) begin
      if (RST || !r_level) begin
         r_hold_cnt <= '0;
         r_hold     <= 1'b0;
      end else if (TICK && (r_hold_cnt != HOLD_LAST)) begin
         r_hold_cnt <= r_hold_cnt + HOLD_CNT_W'(1);
         r_hold     <= (r_hold_cnt == HOLD_LAST - HOLD_CNT_W'(1));
      end else begin
         r_hold     <= 1'b0;
      end
   end

   assign HOLD = r_hold;
`else
   assign HOLD = 1'b0;
`endif

endmodule

// File: rtl/buttons_debouncer.sv
// Board button front end: two-flop synchronisers, a shared free-running
// prescaler producing one TICK per 2^PRESCALE_WIDTH clocks, and NUM_CH
// independent debounce channels. Long-press HOLD pulses are produced only
// when DEBOUNCE_LONG_PRESS_EN is defined; otherwise HOLD reads 0.
module buttons_debouncer
   import debounce_pkg::*;
#(
   parameter int NUM_CH         = DEF_NUM_CH,
   parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH,
   parameter int STABLE_TICKS   = DEF_STABLE_TICKS,
   parameter int LONG_TICKS     = DEF_LONG_TICKS
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [NUM_CH-1:0] BTN_RAW,
   output logic [NUM_CH-1:0] LEVEL,
   output logic [NUM_CH-1:0] PRESS,
   output logic [NUM_CH-1:0] RELEASE,
   output logic [NUM_CH-1:0] HOLD
);

   logic [NUM_CH-1:0]         r_sync1;
   logic [NUM_CH-1:0]         r_sync2;
   logic [PRESCALE_WIDTH-1:0] r_presc;
   logic                      r_tick;

   // Two-flop synchroniser per raw pin
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= BTN_RAW;
         r_sync2 <= r_sync1;
      end
   end

   // Free-running prescaler; registered tick marks each wrap
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_presc <= '0;
         r_tick  <= 1'b0;
      end else begin
         r_presc <= r_presc + PRESCALE_WIDTH'(1);
         r_tick  <= &r_presc;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      debounce_channel #(
         .STABLE_TICKS (STABLE_TICKS),
         .LONG_TICKS   (LONG_TICKS)
      ) u_ch (
         .CLK     (CLK),
         .RST     (RST),
         .TICK    (r_tick),
         .SYNC    (r_sync2[g]),
         .LEVEL   (LEVEL[g]),
         .PRESS   (PRESS[g]),
         .RELEASE (RELEASE[g]),
         .HOLD    (HOLD[g])
      );
   end

endmodule

// File: tb/tb_buttons_debouncer.sv
// Self-checking bench for buttons_debouncer (PRESCALE_WIDTH=2, STABLE_TICKS=3,
// LONG_TICKS=8). A behavioural model tracks consecutive mismatching ticks per
// channel; directed scenarios pin its timing with hand-computed edge counts.
module tb_buttons_debouncer;

   localparam int NCH = 4;
   localparam int PW  = 2;
   localparam int ST  = 3;
   localparam int LT  = 8;

   logic           CLK = 1'b0;
   logic           RST = 1'b1;
   logic [NCH-1:0] BTN_RAW = '0;
   logic [NCH-1:0] LEVEL, PRESS, RELEASE, HOLD;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   buttons_debouncer #(
      .NUM_CH         (NCH),
      .PRESCALE_WIDTH (PW),
      .STABLE_TICKS   (ST),
      .LONG_TICKS     (LT)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .BTN_RAW (BTN_RAW),
      .LEVEL   (LEVEL),
      .PRESS   (PRESS),
      .RELEASE (RELEASE),
      .HOLD    (HOLD)
   );

   always #5 CLK = ~CLK;

   // ---------------- behavioural model ----------------
   // m_j counts clock edges since reset was released; a tick is visible at
   // edge j whenever j-1 is a positive multiple of 2^PW. The synchronised
   // value seen at edge j is the raw value applied two edges earlier.
   int             m_j;
   logic [NCH-1:0] m_h1, m_h2, m_sync, m_lvl_pre;
   logic [NCH-1:0] m_level, m_press, m_rel, m_hold;
   bit             m_tick;
   int             m_streak [NCH];
   int             m_hcnt   [NCH];

   always @(posedge CLK) begin
      if (RST) begin
         m_j = 0;
         m_h1 = '0; m_h2 = '0;
         m_level = '0; m_press = '0; m_rel = '0; m_hold = '0;
         for (int c = 0; c < NCH; c++) begin
            m_streak[c] = 0;
            m_hcnt[c]   = 0;
         end
      end else begin
         m_j++;
         m_tick    = (m_j > 1) && (((m_j - 1) % (1 << PW)) == 0);
         m_sync    = m_h2;
         m_lvl_pre = m_level;
         m_press = '0; m_rel = '0; m_hold = '0;
         for (int c = 0; c < NCH; c++) begin
            if (m_tick) begin
               if (m_sync[c] != m_level[c]) begin
                  m_streak[c]++;
                  if (m_streak[c] == ST) begin
                     m_level[c]  = m_sync[c];
                     m_streak[c] = 0;
                     if (m_sync[c]) m_press[c] = 1'b1;
                     else           m_rel[c]   = 1'b1;
                  end
               end else begin
                  m_streak[c] = 0;
               end
            end
`ifdef DEBOUNCE_LONG_PRESS_EN
            if (!m_lvl_pre[c]) m_hcnt[c] = 0;
            else if (m_tick && m_hcnt[c] < LT) begin
               m_hcnt[c]++;
               if (m_hcnt[c] == LT) m_hold[c] = 1'b1;
            end
`endif
         end
         m_h2 = m_h1;
         m_h1 = BTN_RAW;
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge CLK) begin
      if (chk_en) begin
         checks++;
         if ({LEVEL, PRESS, RELEASE, HOLD} !== {m_level, m_press, m_rel, m_hold}) begin
            failures++;
            $display("FAIL model_cmp t=%0t act L=%b P=%b R=%b H=%b exp L=%b P=%b R=%b H=%b",
                     $time, LEVEL, PRESS, RELEASE, HOLD, m_level, m_press, m_rel, m_hold);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0d exp=%0d", name, act, exp);
      end
   endtask

   task automatic edge_n();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   // One reset edge; returns at the negedge where RST drops, so values
   // assigned afterwards are captured at edge 1.
   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int first, cnt, nh, frel;
      bit rst_pulse;

      do_reset();
      chk_en = 1'b1;
      check("rst_level",   int'(LEVEL),   0);
      check("rst_press",   int'(PRESS),   0);
      check("rst_release", int'(RELEASE), 0);
      check("rst_hold",    int'(HOLD),    0);

      // Clean press on channel 0: ticks sampled at edges 5, 9, 13
      BTN_RAW = 4'b0001;
      first = -1; cnt = 0;
      for (int e = 1; e <= 20; e++) begin
         edge_n();
         if (LEVEL[0] && first < 0) begin
            first = e;
            check("clean_press_pulse", int'(PRESS[0]), 1);
         end
         cnt += int'(PRESS[0]);
      end
      check("clean_latency", first, 13);
      check("clean_npress", cnt, 1);
      check("clean_others", int'(LEVEL[3:1]), 0);

      // Long press: keep holding; HOLD 8 ticks after LEVEL rose (edge 45)
      first = -1; nh = 0;
      for (int e = 21; e <= 100; e++) begin
         edge_n();
         if (HOLD[0]) begin
            nh++;
            if (first < 0) first = e;
         end
      end
`ifdef DEBOUNCE_LONG_PRESS_EN
      check("hold_latency", first, 45);
      check("hold_once", nh, 1);
`else
      check("hold_off", nh, 0);
`endif
      BTN_RAW = 4'b0000;
      for (int e = 0; e < 30; e++) edge_n();
      check("hold_release_level", int'(LEVEL[0]), 0);
      BTN_RAW = 4'b0001;
      nh = 0;
      for (int e = 0; e < 90; e++) begin
         edge_n();
         nh += int'(HOLD[0]);
      end
`ifdef DEBOUNCE_LONG_PRESS_EN
      check("hold_repress", nh, 1);
`else
      check("hold_repress_off", nh, 0);
`endif

      // Bounce on channel 1: sync low at tick edge 13 restarts the count
      do_reset();
      BTN_RAW = 4'b0010;
      first = -1; cnt = 0;
      for (int e = 1; e <= 40; e++) begin
         edge_n();
         if (LEVEL[1] && first < 0) first = e;
         cnt += int'(PRESS[1]);
         if (e == 10) BTN_RAW[1] = 1'b0;
         if (e == 11) BTN_RAW[1] = 1'b1;
      end
      check("bounce_latency", first, 25);
      check("bounce_npress", cnt, 1);

      // Sub-tick glitch on channel 2: sync high only at edges 10 and 11
      do_reset();
      BTN_RAW = 4'b0000;
      cnt = 0;
      for (int e = 1; e <= 40; e++) begin
         edge_n();
         cnt += int'(LEVEL[2]) + int'(PRESS[2]) + int'(RELEASE[2]);
         if (e == 7) BTN_RAW[2] = 1'b1;
         if (e == 9) BTN_RAW[2] = 1'b0;
      end
      check("glitch_invisible", cnt, 0);

      // Simultaneous release of channels 0 and 3
      do_reset();
      BTN_RAW = 4'b1001;
      frel = -1;
      for (int e = 1; e <= 40; e++) begin
         edge_n();
         if (e == 13) check("rel_both_up", int'(LEVEL), 4'b1001);
         if (RELEASE != 0 && frel < 0) begin
            frel = e;
            check("rel_simultaneous", int'(RELEASE), 4'b1001);
         end
         if (e == 14) BTN_RAW = 4'b0000;
      end
      check("rel_latency", frel, 25);
      check("rel_level_low", int'(LEVEL), 0);

      // Reset in the middle of a check, input kept high
      do_reset();
      BTN_RAW = 4'b0001;
      cnt = 0;
      for (int e = 1; e <= 10; e++) begin
         edge_n();
         cnt += int'(PRESS[0]);
      end
      do_reset();
      check("midrst_level", int'(LEVEL[0]), 0);
      check("midrst_nopulse", cnt, 0);
      first = -1;
      for (int e = 1; e <= 20; e++) begin
         edge_n();
         if (PRESS[0] && first < 0) first = e;
      end
      check("midrst_repress", first, 13);

      // Randomised traffic with occasional resets, checked by the model
      do_reset();
      rst_pulse = 1'b0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         edge_n();
         if (rst_pulse) begin
            RST = 1'b0;
            rst_pulse = 1'b0;
         end else if ($urandom_range(0, 599) == 0) begin
            RST = 1'b1;
            rst_pulse = 1'b1;
         end
         for (int c = 0; c < NCH; c++) begin
            if (cyc < 2000) begin
               if ($urandom_range(0, 7) == 0) BTN_RAW[c] = ~BTN_RAW[c];
            end else begin
               if ($urandom_range(0, 59) == 0) BTN_RAW[c] = ~BTN_RAW[c];
            end
         end
      end
      RST = 1'b0;
      edge_n();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
